// File: rtl/rf_read_sb_pkg.sv
// Core-wide register file constants and types.
//   DW       : data width of one architectural register
//   AW       : register number width; NREG = 2**AW registers
//   REG_ZERO : register number of the hardwired-zero register
package rf_read_sb_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard. A bit is set when an instruction with that
// destination issues and cleared when write-back retires the result.
//   clk, clrn       : clock (rising edge), asynchronous active-low reset
//   rna, rnb        : register numbers being read by decode
//   busy_a, busy_b  : the addressed register still has a result in flight
//   we, wn          : write-back enable and register number (clears pending)
//   issue, issue_rd : issuing instruction and its destination (sets pending)
module rf_scoreboard
    import rf_read_sb_pkg::*;
(
    input  logic      clk,
    input  logic      clrn,
    input  reg_addr_t rna,
    input  reg_addr_t rnb,
    output logic      busy_a,
    output logic      busy_b,
    input  logic      we,
    input  reg_addr_t wn,
    input  logic      issue,
    input  reg_addr_t issue_rd
);

    // Register 0 has no flop; its pending bit is the constant 0 below.
    logic [NREG-1:1] pending_q;
    logic [NREG-1:1] pending_d;
    logic [NREG-1:0] pending_all;

    always_comb begin
        pending_d = pending_q;
        if (we && (wn != REG_ZERO)) begin
            pending_d[wn] = 1'b0;
        end
        // Set after clear: a newly issued producer supersedes the retiring one.
        if (issue && (issue_rd != REG_ZERO)) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_all = {pending_q, 1'b0};

    // A same-cycle write-back to the read register is bypassed, so no stall.
    assign busy_a = pending_all[rna] & ~(we && (wn == rna));
    assign busy_b = pending_all[rnb] & ~(we && (wn == rnb));

endmodule

// File: rtl/rf_read_sb.sv
// Register file with two combinational read ports, one write port, same-cycle
// write-to-read bypass and a pending-result scoreboard for hazard stalls.
//   clk, clrn       : clock (rising edge), asynchronous active-low reset
//   rna, rnb        : read register numbers
//   qa, qb          : read data (register 0 reads as zero)
//   busy_a, busy_b  : addressed register has a result in flight
//   we, wn, d       : write-back enable, register number and data
//   issue, issue_rd : issuing instruction and its destination register
module rf_read_sb
    import rf_read_sb_pkg::*;
(
    input  logic      clk,
    input  logic      clrn,
    input  reg_addr_t rna,
    input  reg_addr_t rnb,
    output word_t     qa,
    output word_t     qb,
    output logic      busy_a,
    output logic      busy_b,
    input  logic      we,
    input  reg_addr_t wn,
    input  word_t     d,
    input  logic      issue,
    input  reg_addr_t issue_rd
);

    word_t regs_q [NREG];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wn != REG_ZERO)) begin
            regs_q[wn] <= d;
        end
    end

    // Reads are forced to zero during reset so a bypass cannot leak through.
    always_comb begin
        qa = '0;
        if (clrn && (rna != REG_ZERO)) begin
            if (we && (wn == rna)) begin
                qa = d;
            end else begin
                qa = regs_q[rna];
            end
        end
    end

    always_comb begin
        qb = '0;
        if (clrn && (rnb != REG_ZERO)) begin
            if (we && (wn == rnb)) begin
                qb = d;
            end else begin
                qb = regs_q[rnb];
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .clrn     (clrn),
        .rna      (rna),
        .rnb      (rnb),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .we       (we),
        .wn       (wn),
        .issue    (issue),
        .issue_rd (issue_rd)
    );

endmodule

// File: doc/rf_read_sb.md
Name: rf_read_sb

Overview:
- Register file for the pipelined RISC-V core.
  - One write port, fed by write-back.
  - Two read ports, feeding decode operand fetch.
- Also holds a per-register pending scoreboard.
  - Decode marks a destination as pending at issue.
  - Write-back clears it.
  - Decode reads the busy flags to stall on load-use hazards.
- The core's flop registers store results; this block is the read-side consumer of those results.
  - It provides same-cycle write-to-read bypass.
  - It tracks which results are still in flight.

Parameters:
- DW, 32, data width of each register.
- AW, 5, register address width; NREG = 2**AW registers. Register 0 is hardwired to zero.

Ports:
- clk       in   1   clock, rising-edge.
- clrn      in   1   reset, asynchronous, active-low.
- rna       in   AW  read port A register number.
- rnb       in   AW  read port B register number.
- qa        out  DW  read port A data.
- qb        out  DW  read port B data.
- busy_a    out  1   register rna has a result in flight.
- busy_b    out  1   register rnb has a result in flight.
- we        in   1   write-back enable.
- wn        in   AW  write-back register number.
- d         in   DW  write-back data.
- issue     in   1   an instruction with a destination issues this cycle.
- issue_rd  in   AW  destination register of the issuing instruction.

Behaviour:
- Reset:
  - clrn low clears all registers 1..NREG-1 and all pending bits asynchronously.
  - While clrn is low: qa=qb=0 for any address, busy_a=busy_b=0.
  - Reset asserted mid-operation discards in-flight pending state immediately. No partial write completes.
- Write:
  - On posedge clk, if we=1 and wn!=0, then reg[wn] <= d.
  - wn=0 writes are ignored.
- Read:
  - Combinational, zero latency.
  - qa = 0 if rna=0.
  - Otherwise qa = d if we=1 and wn==rna (bypass).
  - Otherwise qa = reg[rna].
  - qb is identical using rnb.
  - Both ports may read the same register; both receive the same value.
- Scoreboard:
  - pending[NREG-1:1] are flops; pending[0] is a constant 0.
  - At posedge: set pending[issue_rd] if issue=1 and issue_rd!=0.
  - At posedge: clear pending[wn] if we=1 and wn!=0.
  - Same register set and cleared in the same cycle: set wins (a new producer supersedes the retiring one).
  - Set and clear on different registers both take effect.
  - issue to a register already pending keeps the bit set; no counting.
  - Write-back to a non-pending register writes data normally; the pending bit stays 0.
- Busy:
  - busy_a = pending[rna] & ~(we & wn==rna). Same-cycle write-back resolves the hazard via bypass.
  - busy_b is identical using rnb.
  - rna=0 gives busy_a=0.
- Widths:
  - No arithmetic.
  - Address compares use the full AW bits.
  - Out-of-range addresses are impossible (NREG=2**AW).

Decomposition:
- Shared package (core-wide):
  - Constants: DW, AW, REG_ZERO=0.
  - Typedefs: reg_addr_t [AW-1:0] and word_t [DW-1:0].
- Natural sub-module: rf_scoreboard.
  - Contains the pending flops, set/clear priority logic and the busy outputs.
  - Instantiated once in rf_read_sb.
- Storage and bypass muxes stay in the top module.

Test Plan:
- Reset: write reg5=0x1234 and issue rd=5, then pulse clrn low mid-cycle -> immediately qa(rna=5)=0 and busy_a=0, and both stay 0 after release.
- Write and read back:
  - we=1, wn=7, d=0xDEADBEEF; next cycle rna=7, rnb=7 -> qa=qb=0xDEADBEEF.
  - we=1, wn=0, d=0xFFFFFFFF -> qa(rna=0)=0, both the same cycle and the next.
- Bypass: reg3=0x11 stored; same cycle we=1, wn=3, d=0x22, rna=3 -> qa=0x22 combinationally and busy_a=0; next cycle qa=0x22.
- Scoreboard lifecycle:
  - issue rd=9 -> next cycle busy_b(rnb=9)=1, busy_a(rna=8)=0.
  - While pending, we=1, wn=9 -> busy_b=0 in that cycle, and pending is cleared after the edge.
- Simultaneous set/clear:
  - pending[4]=1; issue rd=4 and we=1, wn=4 in the same cycle -> busy_a(rna=4)=0 that cycle, and busy_a=1 the next cycle.
  - issue rd=6 with we wn=10 in the same cycle -> pending6=1, pending10=0.
- x0 scoreboard: issue rd=0 -> busy_a(rna=0)=0 forever; qa=0.
